// File: rtl/spw_babasu_pio_pkg.sv
// Shared constants for the SpaceWire link-status PIO: register map,
// edge-capture mode encodings and the Avalon data width.
package spw_babasu_pio_pkg;

    localparam int AVALON_DATA_W = 32;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RESERVED = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Cycles of edge suppression after reset release: long enough for a
    // level held through reset to settle into prev without looking like an edge.
    function automatic int prime_length(input int sync_stages,
                                        input int debounce_cycles,
                                        input bit debounce_en);
        return sync_stages + 1 + (debounce_en ? debounce_cycles : 0);
    endfunction

endpackage

// File: rtl/spw_babasu_pio_bit_filter.sv
// One status bit: multi-flop synchroniser followed, when
// SPW_STATUS_PIO_DEBOUNCE_EN is defined, by a stability-counter debouncer.
module spw_babasu_pio_bit_filter #(
    parameter int SYNC_STAGES = 2
`ifdef SPW_STATUS_PIO_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

`ifdef SPW_STATUS_PIO_DEBOUNCE_EN
    logic        filt_q;
    logic [15:0] stable_cnt;

    // Accept a new level only after it has differed from the filtered value for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt_q     <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_q != filt_q) begin
            if (stable_cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
                filt_q     <= sync_q;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 16'd1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

    assign dout = filt_q;
`else
    assign dout = sync_q;
`endif

endmodule

// File: rtl/spw_babasu_status_pio.sv
// Avalon-MM status input port for the SpaceWire link status bus:
// synchronised DATA, IRQ mask, W1C edge capture and a level IRQ.
// Optional input debounce is built when SPW_STATUS_PIO_DEBOUNCE_EN is defined.
module spw_babasu_status_pio
    import spw_babasu_pio_pkg::*;
#(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_MODE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               address,
    input  logic                     chipselect,
    input  logic                     write_n,
    input  logic [AVALON_DATA_W-1:0] writedata,
    output logic [AVALON_DATA_W-1:0] readdata,
    input  logic [WIDTH-1:0]         in_port,
    output logic                     irq
);

`ifdef SPW_STATUS_PIO_DEBOUNCE_EN
    localparam bit DEBOUNCE_EN = 1'b1;
`else
    localparam bit DEBOUNCE_EN = 1'b0;
`endif

    // The filtered level also lags by DEBOUNCE_CYCLES, so priming covers it too.
    localparam int PRIME_LEN = prime_length(SYNC_STAGES, DEBOUNCE_CYCLES, DEBOUNCE_EN);
    localparam int PRIME_W   = $clog2(PRIME_LEN + 1);

    logic [WIDTH-1:0]         data_q;
    logic [WIDTH-1:0]         prev_q;
    logic [WIDTH-1:0]         irq_mask;
    logic [WIDTH-1:0]         edge_capture;
    logic [WIDTH-1:0]         rise;
    logic [WIDTH-1:0]         fall;
    logic [WIDTH-1:0]         det;
    logic [WIDTH-1:0]         clr;
    logic [PRIME_W-1:0]       prime_cnt;
    logic                     primed;
    logic                     wr_en;
    logic [AVALON_DATA_W-1:0] rd_next;
    logic                     unused_writedata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
`ifdef SPW_STATUS_PIO_DEBOUNCE_EN
            spw_babasu_pio_bit_filter #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_filter (
                .clk     (clk),
                .reset_n (reset_n),
                .din     (in_port[gi]),
                .dout    (data_q[gi])
            );
`else
            spw_babasu_pio_bit_filter #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_filter (
                .clk     (clk),
                .reset_n (reset_n),
                .din     (in_port[gi]),
                .dout    (data_q[gi])
            );
`endif
        end
    endgenerate

    assign wr_en            = chipselect & ~write_n;
    assign primed           = (prime_cnt == PRIME_W'(PRIME_LEN));
    assign unused_writedata = &{1'b0, writedata};

    // Edge selection, W1C clear mask and read mux
    always_comb begin
        rise = data_q & ~prev_q;
        fall = ~data_q & prev_q;
        case (EDGE_MODE)
            EDGE_FALL: det = fall;
            EDGE_ANY:  det = rise | fall;
            default:   det = rise;
        endcase
        if (!primed) begin
            det = '0;
        end

        clr = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
            clr = writedata[WIDTH-1:0];
        end

        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = data_q;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_capture;
            default:      rd_next = '0;
        endcase
    end

    // Prime counter, edge history, mask, capture and registered read data
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prime_cnt    <= '0;
            prev_q       <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            if (!primed) begin
                prime_cnt <= prime_cnt + 1'b1;
            end
            prev_q <= data_q;
            if (wr_en && address == ADDR_IRQMASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_capture <= (edge_capture & ~clr) | det;
            readdata     <= rd_next;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_spw_babasu_status_pio.sv
// Directed bench for spw_babasu_status_pio: one rising-edge and one any-edge
// instance share the bus and inputs; expected values are hand-computed.
// Define SPW_STATUS_PIO_DEBOUNCE_EN for the debounce section.
module tb_spw_babasu_status_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [2:0]  in_port;
    logic [31:0] rd_rise, rd_any;
    logic        irq_rise, irq_any;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spw_babasu_status_pio #(
        .WIDTH(3), .SYNC_STAGES(2), .EDGE_MODE(0), .DEBOUNCE_CYCLES(16)
    ) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
        .in_port(in_port), .irq(irq_rise)
    );

    spw_babasu_status_pio #(
        .WIDTH(3), .SYNC_STAGES(2), .EDGE_MODE(2), .DEBOUNCE_CYCLES(16)
    ) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_any),
        .in_port(in_port), .irq(irq_any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] r0, output logic [31:0] r2);
        address = a;
        tick(1);
        r0 = rd_rise;
        r2 = rd_any;
    endtask

    logic [31:0] r0, r2;

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 3'b101;

        // Reset state with inputs already high
        tick(3);
        check("rst_rd_rise", rd_rise, 32'h0);
        check("rst_rd_any", rd_any, 32'h0);
        check("rst_irq", {30'd0, irq_rise, irq_any}, 32'h0);

        // Release: DATA valid, no spurious capture from the held-high bits
        reset_n = 1'b1;
        tick(3);
        bus_read(2'd0, r0, r2);
        check("data_101_rise", r0, 32'h5);
        check("data_101_any", r2, 32'h5);
        bus_read(2'd3, r0, r2);
        check("prime_cap_rise", r0, 32'h0);
        check("prime_cap_any", r2, 32'h0);
        check("prime_irq", {30'd0, irq_rise, irq_any}, 32'h0);

        // Rising edge on bit1 with bit1 unmasked
        bus_write(2'd2, 32'h2);
        in_port = 3'b111;
        tick(2);
        check("rise_lat_irq", {30'd0, irq_rise, irq_any}, 32'h0);
        tick(1);
        check("rise_irq", {30'd0, irq_rise, irq_any}, 32'h3);
        bus_read(2'd3, r0, r2);
        check("rise_cap_rise", r0, 32'h2);
        check("rise_cap_any", r2, 32'h2);
        bus_write(2'd3, 32'h2);
        check("w1c_irq", {30'd0, irq_rise, irq_any}, 32'h0);
        bus_read(2'd3, r0, r2);
        check("w1c_cap", {r0[15:0], r2[15:0]}, 32'h0);

        // Falling edge on bit1: only the any-edge instance captures
        in_port = 3'b101;
        tick(3);
        check("fall_irq", {30'd0, irq_rise, irq_any}, 32'h1);
        bus_read(2'd3, r0, r2);
        check("fall_cap_rise", r0, 32'h0);
        check("fall_cap_any", r2, 32'h2);
        bus_write(2'd3, 32'h2);

        // Masked capture of a short bit0 pulse, then unmask
        bus_write(2'd2, 32'h0);
        in_port = 3'b100;
        tick(4);
        bus_write(2'd3, 32'h7);
        bus_read(2'd3, r0, r2);
        check("pre_pulse_cap", {r0[15:0], r2[15:0]}, 32'h0);
        in_port = 3'b101;
        tick(1);
        in_port = 3'b100;
        tick(4);
        bus_read(2'd3, r0, r2);
        check("pulse_cap_rise", r0, 32'h1);
        check("pulse_cap_any", r2, 32'h1);
        check("masked_irq", {30'd0, irq_rise, irq_any}, 32'h0);
        bus_write(2'd2, 32'h1);
        check("unmask_irq", {30'd0, irq_rise, irq_any}, 32'h3);
        bus_write(2'd3, 32'h1);
        check("clr0_irq", {30'd0, irq_rise, irq_any}, 32'h0);

        // W1C on bit2 in the same cycle as a new bit2 capture
        in_port = 3'b000;
        tick(4);
        bus_write(2'd3, 32'h7);
        in_port = 3'b100;
        tick(2);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, r0, r2);
        check("set_wins_rise", r0, 32'h4);
        check("set_wins_any", r2, 32'h4);
        check("bit2_masked_irq", {30'd0, irq_rise, irq_any}, 32'h0);

        // Mask width, reserved address, DATA readback
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, r0, r2);
        check("mask_rb_rise", r0, 32'h7);
        check("mask_rb_any", r2, 32'h7);
        check("full_mask_irq", {30'd0, irq_rise, irq_any}, 32'h3);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, r0, r2);
        check("reserved_rd", {r0[15:0], r2[15:0]}, 32'h0);
        check("reserved_hi", {r0[31:16], r2[31:16]}, 32'h0);
        bus_read(2'd0, r0, r2);
        check("data_100", r0, 32'h4);

        // Reset mid-operation with irq pending
        address = 2'd3;
        reset_n = 1'b0;
        tick(1);
        check("midrst_irq", {30'd0, irq_rise, irq_any}, 32'h0);
        check("midrst_rd", {r0[31:0] & 32'h0 | rd_rise}, 32'h0);
        check("midrst_rd_any", rd_any, 32'h0);
        reset_n = 1'b1;
        tick(3);
        bus_read(2'd2, r0, r2);
        check("midrst_mask", {r0[15:0], r2[15:0]}, 32'h0);
        bus_read(2'd3, r0, r2);
        check("midrst_cap", {r0[15:0], r2[15:0]}, 32'h0);

`ifdef SPW_STATUS_PIO_DEBOUNCE_EN
        // Debounce: 10-cycle glitch rejected, long pulse accepted after 2+16 cycles
        in_port = 3'b000;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(40);
        in_port = 3'b001;
        tick(10);
        in_port = 3'b000;
        tick(30);
        bus_read(2'd0, r0, r2);
        check("db_short_data", {r0[15:0], r2[15:0]}, 32'h0);
        bus_read(2'd3, r0, r2);
        check("db_short_cap", {r0[15:0], r2[15:0]}, 32'h0);
        in_port = 3'b001;
        tick(17);
        bus_read(2'd0, r0, r2);
        check("db_edge_before", r0, 32'h0);
        bus_read(2'd0, r0, r2);
        check("db_edge_after", r0, 32'h1);
        in_port = 3'b000;
        tick(25);
        bus_read(2'd3, r0, r2);
        check("db_long_cap_rise", r0, 32'h1);
        check("db_long_cap_any", r2, 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
